vram_loader: RTL and testbench

//  Upstream fill stage for the video RAM. On start, it sweeps the image ROM address space, reads

---
 rtl/vram_pkg.sv | 15 +
 rtl/lat_pipe.sv | 43 ++++
 rtl/vram_loader.sv | 88 ++++++++
 tb/tb_vram_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Constants and state encoding shared by the video RAM, the fill stage and the scan-out logic.
package vram_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_DEPTH  = 2048;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } loader_state_t;

endpackage

// File: rtl/lat_pipe.sv
// ROM_LAT-deep delay line of {valid, addr} that tracks ROM reads in flight.
module lat_pipe #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic              pending
);

    logic [LAT:1]             vld_pipe;
    logic [LAT:1][ADDR_W-1:0] addr_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= in_vld;
            addr_pipe[1] <= in_addr;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LAT];
    assign out_addr = addr_pipe[LAT];

    // Reads still travelling toward the output stage; the one at the output retires this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            pending = pending | vld_pipe[i];
        end
    end

endmodule

// File: rtl/vram_loader.sv
// Copies ROM addresses 0..DEPTH-1 into the VRAM write port, one word per clock, pausable.
module vram_loader
    import vram_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int DEPTH   = VRAM_DEPTH,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_out
);

    // One extra bit so DEPTH = 2**ADDR_W reaches its last index without wrapping.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    loader_state_t   state, state_nxt;
    logic [ADDR_W:0] issue_cnt;
    logic            issue;
    logic            pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            words_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                issue_cnt <= '0;
                words_out <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
                if (ram_ce) words_out <= words_out + (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                issue = !pause;
                if (issue && issue_cnt == LAST) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!pending) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    lat_pipe #(
        .LAT    (ROM_LAT),
        .ADDR_W (ADDR_W)
    ) u_lat_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (issue),
        .in_addr  (issue_cnt[ADDR_W-1:0]),
        .out_vld  (ram_ce),
        .out_addr (ram_ad),
        .pending  (pending)
    );

    assign rom_ad   = issue_cnt[ADDR_W-1:0];
    assign ram_data = rom_data;
    assign busy     = (state == RUN) || (state == FLUSH);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: three configurations driven from a vector table plus reset corner cases.
module tb_vram_loader;

    logic clk = 1'b0;
    logic reset;
    logic start, pause;
    int   sel;

    logic [2:0]  start_v, pause_v;
    logic [10:0] rom_ad_v [3];
    logic [7:0]  rom_data_v [3];
    logic        ram_ce_v [3];
    logic [10:0] ram_ad_v [3];
    logic [7:0]  ram_data_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [11:0] words_v [3];

    logic [7:0]  mem [2048];
    logic [10:0] rq [3][3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int dep_of(input int g);
        case (g)
            0:       return 16;
            1:       return 8;
            default: return 2048;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            start_v[g] = (sel == g) && start;
            pause_v[g] = (sel == g) && pause;
        end
    end

    // Behavioural ROM: a fixed number of clocks from address to data.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            rq[g][0] <= rom_ad_v[g];
            rq[g][1] <= rq[g][0];
            rq[g][2] <= rq[g][1];
        end
    end

    always_comb begin
        for (int g = 0; g < 3; g++) rom_data_v[g] = mem[rq[g][lat_of(g)-1]];
    end

    vram_loader #(.ADDR_W(11), .DATA_W(8), .DEPTH(16), .ROM_LAT(1)) u_d16 (
        .clk(clk), .reset(reset), .start(start_v[0]), .pause(pause_v[0]),
        .rom_ad(rom_ad_v[0]), .rom_data(rom_data_v[0]), .ram_ce(ram_ce_v[0]),
        .ram_ad(ram_ad_v[0]), .ram_data(ram_data_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .words_out(words_v[0]));

    vram_loader #(.ADDR_W(11), .DATA_W(8), .DEPTH(8), .ROM_LAT(3)) u_d8 (
        .clk(clk), .reset(reset), .start(start_v[1]), .pause(pause_v[1]),
        .rom_ad(rom_ad_v[1]), .rom_data(rom_data_v[1]), .ram_ce(ram_ce_v[1]),
        .ram_ad(ram_ad_v[1]), .ram_data(ram_data_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .words_out(words_v[1]));

    vram_loader #(.ADDR_W(11), .DATA_W(8), .DEPTH(2048), .ROM_LAT(1)) u_d2k (
        .clk(clk), .reset(reset), .start(start_v[2]), .pause(pause_v[2]),
        .rom_ad(rom_ad_v[2]), .rom_data(rom_data_v[2]), .ram_ce(ram_ce_v[2]),
        .ram_ad(ram_ad_v[2]), .ram_data(ram_data_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .words_out(words_v[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < 2048; i++) mem[i] = rnd ? 8'($urandom) : (8'(i) ^ 8'hA5);
    endtask

    // Reference schedule: issue slots are the unpaused busy cycles; writes follow by the ROM latency.
    bit pz [4400];
    int ia [4400];
    int wa [4400];

    typedef struct {
        int sel;
        int plo;
        int phi;
        bit rnd_pause;
        bit rnd_rom;
        int rs;        // 0: no extra start, -1: start during the done cycle, else busy-cycle index
        int exp_busy;  // -1: take it from the reference schedule
    } vec_t;

    task automatic run_copy(input vec_t v, input int idx);
        int dep, lat, issued, last, t, busy_cnt, done_cnt, rs;
        logic [32:0] ev, av;
        bit ce, isu;
        dep = dep_of(v.sel);
        lat = lat_of(v.sel);
        fill_rom(v.rnd_rom);
        for (int k = 0; k < 4400; k++) begin
            pz[k] = ((k >= v.plo) && (k <= v.phi)) || (v.rnd_pause && ($urandom_range(0, 3) == 0));
            ia[k] = -1;
            wa[k] = -1;
        end
        issued = 0;
        last = 0;
        for (int k = 1; issued < dep; k++) begin
            if (!pz[k]) begin
                ia[k] = issued;
                wa[k + lat] = issued;
                issued++;
                last = k;
            end
        end
        t = last + lat + 3;
        rs = (v.rs == -1) ? last + lat + 1 : v.rs;
        busy_cnt = 0;
        done_cnt = 0;

        sel = v.sel;
        @(negedge clk);
        start = 1'b1;
        pause = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= t; k++) begin
            #1;
            start = (k == rs);
            pause = pz[k];
            @(negedge clk);
            ce  = (wa[k] >= 0);
            isu = (ia[k] >= 0);
            ev = {ce, ce ? 11'(wa[k]) : 11'd0, ce ? mem[wa[k]] : 8'd0,
                  k <= last + lat, k == last + lat + 1, isu ? 11'(ia[k]) : 11'd0};
            av = {ram_ce_v[sel], ram_ce_v[sel] ? ram_ad_v[sel] : 11'd0,
                  ram_ce_v[sel] ? ram_data_v[sel] : 8'd0,
                  busy_v[sel], done_v[sel], isu ? rom_ad_v[sel] : 11'd0};
            if (ev !== av) begin
                checks++;
                failures++;
                $display("FAIL vec%0d cyc%0d {ce,ad,data,busy,done,rom_ad}: got %0h expected %0h",
                         idx, k, av, ev);
            end
            if (busy_v[sel]) busy_cnt++;
            if (done_v[sel]) done_cnt++;
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        pause = 1'b0;
        @(negedge clk);
        checks++;
        chk($sformatf("vec%0d busy_cycles", idx), 64'(busy_cnt),
            64'((v.exp_busy >= 0) ? v.exp_busy : last + lat));
        chk($sformatf("vec%0d done_count", idx), 64'(done_cnt), 64'd1);
        chk($sformatf("vec%0d words_out", idx), 64'(words_v[sel]), 64'(dep));
        chk($sformatf("vec%0d idle_after", idx), 64'(busy_v[sel]), 64'd0);
    endtask

    vec_t vecs [10];

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit hit;
        vecs[0] = '{sel: 0, plo: 0, phi: -1, rnd_pause: 0, rnd_rom: 0, rs: 0,  exp_busy: 17};
        vecs[1] = '{sel: 0, plo: 4, phi: 9,  rnd_pause: 0, rnd_rom: 0, rs: 0,  exp_busy: 23};
        vecs[2] = '{sel: 1, plo: 0, phi: -1, rnd_pause: 0, rnd_rom: 0, rs: 0,  exp_busy: 11};
        vecs[3] = '{sel: 0, plo: 0, phi: -1, rnd_pause: 0, rnd_rom: 1, rs: 5,  exp_busy: 17};
        vecs[4] = '{sel: 0, plo: 0, phi: -1, rnd_pause: 0, rnd_rom: 1, rs: -1, exp_busy: 17};
        vecs[5] = '{sel: 1, plo: 9, phi: 12, rnd_pause: 0, rnd_rom: 1, rs: 0,  exp_busy: 11};
        vecs[6] = '{sel: 0, plo: 0, phi: -1, rnd_pause: 1, rnd_rom: 1, rs: 0,  exp_busy: -1};
        vecs[7] = '{sel: 1, plo: 0, phi: -1, rnd_pause: 1, rnd_rom: 1, rs: 0,  exp_busy: -1};
        vecs[8] = '{sel: 1, plo: 1, phi: 3,  rnd_pause: 0, rnd_rom: 1, rs: 0,  exp_busy: 14};
        vecs[9] = '{sel: 2, plo: 0, phi: -1, rnd_pause: 0, rnd_rom: 1, rs: 0,  exp_busy: 2049};

        sel = 0;
        start = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        fill_rom(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset%0d {rom_ad,ce,ram_ad,busy,done,words}", g),
                64'({rom_ad_v[g], ram_ce_v[g], ram_ad_v[g], busy_v[g], done_v[g], words_v[g]}),
                64'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_copy(vecs[i], i);

        // Reset lands while word 7 is being written; the run must die quietly.
        sel = 0;
        fill_rom(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            hit = ram_ce_v[0] && (ram_ad_v[0] == 11'd7);
        end
        chk("midrun_word7_seen", 64'(hit), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_reset {ce,busy,done,words}",
            64'({ram_ce_v[0], busy_v[0], done_v[0], words_v[0]}), 64'd0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n += int'(done_v[0]) + int'(ram_ce_v[0]) + int'(busy_v[0]);
        end
        chk("midrun_no_activity_after_reset", 64'(n), 64'd0);

        // start and reset in the same cycle: reset wins.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_with_reset busy", 64'(busy_v[0]), 64'd0);
        @(negedge clk);
        chk("start_with_reset stays_idle", 64'(busy_v[0]), 64'd0);

        run_copy(vecs[0], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
